// File: rtl/batch_dispatcher_if.sv
// -----------------------------------------------------------------------------
// batch_dispatcher_if
//
// Bundles every non-clock/reset signal of batch_dispatcher:
//   s_axis_*       transaction input stream from the scheduler (valid/ready)
//   batch_end      one-cycle pulse closing the batch being collected
//   d_*            dispatch port to the execution engine (valid/ready)
//   done_*         per-slot completion strobe from the engine
//   batch_*_mask   OR of the read/write sets of the buffered batch
//   status         batch_retired pulse, sticky error/timeout flags, counters
//
// Modports:
//   slave  - the dispatcher itself
//   master - the environment (scheduler + engine side)
// -----------------------------------------------------------------------------
interface batch_dispatcher_if #(
   parameter int MAX_DEPENDENCIES = 256,
   parameter int SLOT_W           = 3
);
   logic                        s_axis_tvalid;
   logic                        s_axis_tready;
   logic [63:0]                 s_axis_tdata_owner_programID;
   logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies;
   logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies;
   logic                        batch_end;

   logic                        d_valid;
   logic                        d_ready;
   logic [63:0]                 d_programID;
   logic [SLOT_W-1:0]           d_slot;

   logic                        done_valid;
   logic [SLOT_W-1:0]           done_slot;

   logic [MAX_DEPENDENCIES-1:0] batch_read_mask;
   logic [MAX_DEPENDENCIES-1:0] batch_write_mask;
   logic                        batch_retired;
   logic                        completion_error;
   logic                        watchdog_timeout;
   logic [31:0]                 batches_retired;
   logic [31:0]                 txns_dispatched;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata_owner_programID,
             s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
             batch_end, d_ready, done_valid, done_slot,
      output s_axis_tready, d_valid, d_programID, d_slot,
             batch_read_mask, batch_write_mask, batch_retired,
             completion_error, watchdog_timeout, batches_retired, txns_dispatched
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata_owner_programID,
             s_axis_tdata_read_dependencies, s_axis_tdata_write_dependencies,
             batch_end, d_ready, done_valid, done_slot,
      input  s_axis_tready, d_valid, d_programID, d_slot,
             batch_read_mask, batch_write_mask, batch_retired,
             completion_error, watchdog_timeout, batches_retired, txns_dispatched
   );
endinterface

// File: rtl/batch_dispatcher.sv
// -----------------------------------------------------------------------------
// batch_dispatcher
//
// Collects conflict-free transactions from the scheduler stream into one batch
// buffer, dispatches them in slot order to the execution engine, tracks
// per-slot completions and retires the batch once every slot has completed.
// The OR of the batch's read/write dependency sets is held until retirement.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - batch_dispatcher_if.slave (stream in, dispatch out, completions
//          in, masks / status / counters out)
//
// Optional feature: define BATCH_DISPATCHER_WATCHDOG_EN to add a WAIT-state
// watchdog that force-retires a batch after WATCHDOG_CYCLES cycles without a
// legal completion and sets the sticky watchdog_timeout flag. Without the
// macro, watchdog_timeout is tied to 0.
// -----------------------------------------------------------------------------
module batch_dispatcher #(
   parameter int MAX_DEPENDENCIES = 256,
   parameter int MAX_BATCH_SIZE   = 8,
   parameter int SLOT_W           = 3,
   parameter int WATCHDOG_CYCLES  = 1024
) (
   input logic               clk,
   input logic               rst,
   batch_dispatcher_if.slave bus
);

   if (MAX_BATCH_SIZE < 2 || MAX_BATCH_SIZE != (1 << SLOT_W) || WATCHDOG_CYCLES < 2)
   begin : g_param_check
      $error("batch_dispatcher: inconsistent parameters");
   end

   // count/dptr need one extra bit so a full batch (count == MAX_BATCH_SIZE)
   // is representable.
   localparam int CNT_W = SLOT_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_BATCH_SIZE);

   typedef enum logic [1:0] {
      ST_COLLECT,
      ST_DISPATCH,
      ST_WAIT,
      ST_RETIRE
   } state_t;

   state_t                      state;
   logic [CNT_W-1:0]            count;
   logic [CNT_W-1:0]            dptr;
   logic [MAX_BATCH_SIZE-1:0]   done;
   logic [63:0]                 id_buf [MAX_BATCH_SIZE];
   logic [MAX_DEPENDENCIES-1:0] rd_mask;
   logic [MAX_DEPENDENCIES-1:0] wr_mask;
   logic [31:0]                 batches_q;
   logic [31:0]                 txns_q;
   logic                        error_q;

   // ---------------------------------------------------------------- decode
   logic                      in_collect;
   logic                      in_dispatch;
   logic                      beat_accept;
   logic [CNT_W-1:0]          count_inc;
   logic                      close_batch;
   logic                      dispatch_fire;
   logic                      last_dispatch;
   logic [CNT_W-1:0]          slot_ext;
   logic                      done_legal;
   logic [MAX_BATCH_SIZE-1:0] done_set;
   logic [MAX_BATCH_SIZE-1:0] slot_live;
   logic                      all_done_next;

   assign in_collect    = (state == ST_COLLECT);
   assign in_dispatch   = (state == ST_DISPATCH);
   assign beat_accept   = bus.s_axis_tvalid && bus.s_axis_tready;
   assign count_inc     = count + CNT_W'(1);

   // A beat arriving together with batch_end belongs to the closing batch;
   // batch_end on an empty batch with no beat does nothing.
   assign close_batch   = in_collect &&
                          ((bus.batch_end && (count != '0 || beat_accept)) ||
                           (beat_accept && count_inc == FULL));

   assign dispatch_fire = in_dispatch && bus.d_ready;
   assign last_dispatch = dispatch_fire && (dptr == count - CNT_W'(1));

   // Comparing against the pre-handshake dptr makes a same-cycle dispatch and
   // completion of one slot illegal.
   assign slot_ext   = {1'b0, bus.done_slot};
   assign done_legal = bus.done_valid &&
                       (state == ST_DISPATCH || state == ST_WAIT) &&
                       (slot_ext < dptr) && (slot_ext < count) &&
                       !done[bus.done_slot];

   // NOTE: every always_comb target gets a default before any conditional
   // logic so no path can leave it unassigned and infer a latch.
   always_comb begin
      done_set  = '0;
      slot_live = '0;
      for (int i = 0; i < MAX_BATCH_SIZE; i++) begin
         done_set[i]  = done_legal && (bus.done_slot == SLOT_W'(i));
         slot_live[i] = (CNT_W'(i) < count);
      end
   end

   // Includes this cycle's completion so retirement follows it by one cycle.
   assign all_done_next = (((done | done_set) & slot_live) == slot_live);

`ifdef BATCH_DISPATCHER_WATCHDOG_EN
   localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic [WD_W-1:0] wd_cnt_inc;
   logic            wd_timeout_q;
   assign wd_cnt_inc = wd_cnt + WD_W'(1);
`endif

   // ------------------------------------------------------------ main FSM
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_COLLECT;
         count     <= '0;
         dptr      <= '0;
         done      <= '0;
         rd_mask   <= '0;
         wr_mask   <= '0;
         batches_q <= '0;
         txns_q    <= '0;
         error_q   <= 1'b0;
`ifdef BATCH_DISPATCHER_WATCHDOG_EN
         wd_cnt       <= '0;
         wd_timeout_q <= 1'b0;
`endif
      end else begin
         // Any completion that is not legal (wrong state, undispatched,
         // out of range or duplicate) is dropped and flagged.
         if (bus.done_valid && !done_legal) begin
            error_q <= 1'b1;
         end

         case (state)
            ST_COLLECT: begin
               if (beat_accept) begin
                  count   <= count_inc;
                  rd_mask <= rd_mask | bus.s_axis_tdata_read_dependencies;
                  wr_mask <= wr_mask | bus.s_axis_tdata_write_dependencies;
               end
               if (close_batch) begin
                  state <= ST_DISPATCH;
               end
            end

            ST_DISPATCH: begin
               done <= done | done_set;
               if (dispatch_fire) begin
                  dptr   <= dptr + CNT_W'(1);
                  txns_q <= txns_q + 32'd1;
               end
               if (last_dispatch) begin
                  state <= ST_WAIT;
`ifdef BATCH_DISPATCHER_WATCHDOG_EN
                  // Counts the cycles elapsed, inclusive of the current one,
                  // since WAIT entry or the last legal completion.
                  wd_cnt <= WD_W'(1);
`endif
               end
            end

            ST_WAIT: begin
               done <= done | done_set;
               if (all_done_next) begin
                  state <= ST_RETIRE;
               end
`ifdef BATCH_DISPATCHER_WATCHDOG_EN
               else if (done_legal) begin
                  wd_cnt <= WD_W'(1);
               end else if (wd_cnt_inc >= WD_W'(WATCHDOG_CYCLES)) begin
                  state        <= ST_RETIRE;
                  wd_timeout_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt_inc;
               end
`endif
            end

            ST_RETIRE: begin
               // Masks stay visible through this cycle and clear on exit.
               batches_q <= batches_q + 32'd1;
               count     <= '0;
               dptr      <= '0;
               done      <= '0;
               rd_mask   <= '0;
               wr_mask   <= '0;
               state     <= ST_COLLECT;
            end

            default: state <= ST_COLLECT;
         endcase
      end
   end

   // NOTE: the ID buffer is storage, not control, so it has no reset; every
   // readable slot is written before it can be dispatched, and d_programID is
   // gated to 0 outside DISPATCH.
   always_ff @(posedge clk) begin
      if (beat_accept) begin
         id_buf[count[SLOT_W-1:0]] <= bus.s_axis_tdata_owner_programID;
      end
   end

   // --------------------------------------------------------------- outputs
   // All outputs are decodes of registered state, so they are glitch-free
   // and land one cycle after the event that causes them.
   assign bus.s_axis_tready    = in_collect && (count < FULL);
   assign bus.d_valid          = in_dispatch;
   assign bus.d_slot           = in_dispatch ? dptr[SLOT_W-1:0] : '0;
   assign bus.d_programID      = in_dispatch ? id_buf[dptr[SLOT_W-1:0]] : 64'd0;
   assign bus.batch_read_mask  = rd_mask;
   assign bus.batch_write_mask = wr_mask;
   assign bus.batch_retired    = (state == ST_RETIRE);
   assign bus.completion_error = error_q;
   assign bus.batches_retired  = batches_q;
   assign bus.txns_dispatched  = txns_q;
`ifdef BATCH_DISPATCHER_WATCHDOG_EN
   assign bus.watchdog_timeout = wd_timeout_q;
`else
   assign bus.watchdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_batch_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_batch_dispatcher
//
// Directed bench for batch_dispatcher. Inputs change 1 ns after a rising
// edge, and outputs are sampled at that point, i.e. they reflect the state
// registered on the preceding edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_batch_dispatcher;

   localparam int MD = 256;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   batch_dispatcher_if #(.MAX_DEPENDENCIES(MD), .SLOT_W(SW)) bus ();

   batch_dispatcher #(
      .MAX_DEPENDENCIES(MD),
      .MAX_BATCH_SIZE  (8),
      .SLOT_W          (SW),
      .WATCHDOG_CYCLES (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   // ------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.s_axis_tvalid                   = 1'b0;
      bus.s_axis_tdata_owner_programID    = '0;
      bus.s_axis_tdata_read_dependencies  = '0;
      bus.s_axis_tdata_write_dependencies = '0;
      bus.batch_end                       = 1'b0;
      bus.d_ready                         = 1'b0;
      bus.done_valid                      = 1'b0;
      bus.done_slot                       = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic beat(input logic [63:0] id, input logic [MD-1:0] rd,
                       input logic [MD-1:0] wr, input logic be);
      bus.s_axis_tvalid                   = 1'b1;
      bus.s_axis_tdata_owner_programID    = id;
      bus.s_axis_tdata_read_dependencies  = rd;
      bus.s_axis_tdata_write_dependencies = wr;
      bus.batch_end                       = be;
      tick();
      bus.s_axis_tvalid                   = 1'b0;
      bus.s_axis_tdata_read_dependencies  = '0;
      bus.s_axis_tdata_write_dependencies = '0;
      bus.batch_end                       = 1'b0;
   endtask

   task automatic drain(input int n);
      bus.d_ready = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bus.d_ready = 1'b0;
   endtask

   task automatic complete(input int s);
      bus.done_valid = 1'b1;
      bus.done_slot  = SW'(s);
      tick();
      bus.done_valid = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      idle_inputs();
      do_reset();
      total += 9;
      if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_tready: got %b want 1", bus.s_axis_tready); end
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid: got %b want 0", bus.d_valid); end
      if (bus.d_programID !== 64'd0) begin bad++; $display("FAIL reset_d_programID: got %h want 0", bus.d_programID); end
      if (bus.batch_read_mask !== '0) begin bad++; $display("FAIL reset_rd_mask: got nonzero want 0"); end
      if (bus.batch_write_mask !== '0) begin bad++; $display("FAIL reset_wr_mask: got nonzero want 0"); end
      if (bus.batch_retired !== 1'b0) begin bad++; $display("FAIL reset_retired: got %b want 0", bus.batch_retired); end
      if (bus.completion_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", bus.completion_error); end
      if (bus.watchdog_timeout !== 1'b0) begin bad++; $display("FAIL reset_wd: got %b want 0", bus.watchdog_timeout); end
      if (bus.batches_retired !== 32'd0 || bus.txns_dispatched !== 32'd0) begin
         bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.batches_retired, bus.txns_dispatched);
      end
   endtask

   task automatic test_auto_close();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL auto_tready_beat%0d: got %b want 1", i, bus.s_axis_tready); end
         beat(64'h10 + 64'(i), '0, '0, 1'b0);
      end
      total += 2;
      if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL auto_tready_full: got %b want 0", bus.s_axis_tready); end
      if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL auto_first_dvalid: got %b want 1", bus.d_valid); end
      bus.d_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (bus.d_valid !== 1'b1 || bus.d_programID !== 64'h10 + 64'(i) || bus.d_slot !== SW'(i)) begin
            bad++; $display("FAIL auto_dispatch%0d: got v=%b id=%h slot=%0d want v=1 id=%h slot=%0d",
                            i, bus.d_valid, bus.d_programID, bus.d_slot, 64'h10 + 64'(i), i);
         end
         tick();
      end
      bus.d_ready = 1'b0;
      total += 2;
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL auto_dvalid_drop: got %b want 0", bus.d_valid); end
      if (bus.txns_dispatched !== 32'd8) begin bad++; $display("FAIL auto_txns: got %0d want 8", bus.txns_dispatched); end
      for (int s = 7; s >= 1; s--) begin
         complete(s);
         total++;
         if (bus.batch_retired !== 1'b0) begin bad++; $display("FAIL auto_early_retire_slot%0d: got 1 want 0", s); end
      end
      complete(0);
      total += 2;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL auto_retire_pulse: got %b want 1", bus.batch_retired); end
      if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL auto_tready_retire: got %b want 0", bus.s_axis_tready); end
      tick();
      total += 4;
      if (bus.batch_retired !== 1'b0) begin bad++; $display("FAIL auto_retire_once: got %b want 0", bus.batch_retired); end
      if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL auto_tready_back: got %b want 1", bus.s_axis_tready); end
      if (bus.batches_retired !== 32'd1) begin bad++; $display("FAIL auto_batches: got %0d want 1", bus.batches_retired); end
      if (bus.completion_error !== 1'b0) begin bad++; $display("FAIL auto_error: got %b want 0", bus.completion_error); end
   endtask

   task automatic test_batch_end();
      beat(64'hA0, '0, '0, 1'b0);
      beat(64'hA1, '0, '0, 1'b0);
      beat(64'hA2, '0, '0, 1'b1);
      total += 2;
      if (bus.d_valid !== 1'b1) begin bad++; $display("FAIL be_close_dvalid: got %b want 1", bus.d_valid); end
      if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL be_close_tready: got %b want 0", bus.s_axis_tready); end
      bus.d_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.d_programID !== 64'hA0 + 64'(i) || bus.d_slot !== SW'(i)) begin
            bad++; $display("FAIL be_dispatch%0d: got id=%h slot=%0d want id=%h slot=%0d",
                            i, bus.d_programID, bus.d_slot, 64'hA0 + 64'(i), i);
         end
         tick();
      end
      bus.d_ready = 1'b0;
      total += 2;
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL be_batch_of_3: got d_valid=%b want 0", bus.d_valid); end
      if (bus.txns_dispatched !== 32'd11) begin bad++; $display("FAIL be_txns: got %0d want 11", bus.txns_dispatched); end
      complete(0);
      complete(1);
      complete(2);
      total++;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL be_retire: got %b want 1", bus.batch_retired); end
      tick();
      bus.batch_end = 1'b1;
      tick();
      bus.batch_end = 1'b0;
      total += 2;
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL be_empty_ignored: got d_valid=%b want 0", bus.d_valid); end
      if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL be_empty_tready: got %b want 1", bus.s_axis_tready); end
      tick();
      total += 2;
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL be_empty_later: got d_valid=%b want 0", bus.d_valid); end
      if (bus.batches_retired !== 32'd2) begin bad++; $display("FAIL be_batches: got %0d want 2", bus.batches_retired); end
   endtask

   task automatic test_backpressure();
      beat(64'hB0, '0, '0, 1'b0);
      beat(64'hB1, '0, '0, 1'b0);
      beat(64'hB2, '0, '0, 1'b0);
      beat(64'hB3, '0, '0, 1'b1);
      drain(2);
      for (int c = 0; c < 5; c++) begin
         total++;
         if (bus.d_valid !== 1'b1 || bus.d_programID !== 64'hB2 || bus.d_slot !== SW'(2)) begin
            bad++; $display("FAIL bp_hold_cycle%0d: got v=%b id=%h slot=%0d want v=1 id=b2 slot=2",
                            c, bus.d_valid, bus.d_programID, bus.d_slot);
         end
         tick();
      end
      bus.d_ready = 1'b1;
      for (int i = 2; i < 4; i++) begin
         total++;
         if (bus.d_valid !== 1'b1 || bus.d_programID !== 64'hB0 + 64'(i) || bus.d_slot !== SW'(i)) begin
            bad++; $display("FAIL bp_resume%0d: got v=%b id=%h slot=%0d want v=1 id=%h slot=%0d",
                            i, bus.d_valid, bus.d_programID, bus.d_slot, 64'hB0 + 64'(i), i);
         end
         tick();
      end
      bus.d_ready = 1'b0;
      total += 2;
      if (bus.d_valid !== 1'b0) begin bad++; $display("FAIL bp_done: got d_valid=%b want 0", bus.d_valid); end
      if (bus.txns_dispatched !== 32'd15) begin bad++; $display("FAIL bp_txns: got %0d want 15", bus.txns_dispatched); end
      for (int s = 0; s < 4; s++) complete(s);
      total++;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL bp_retire: got %b want 1", bus.batch_retired); end
      tick();
   endtask

   task automatic test_masks();
      logic [MD-1:0] one;
      logic [MD-1:0] exp_rd;
      logic [MD-1:0] exp_wr;
      one    = MD'(1);
      exp_rd = (one << 3) | (one << 200);
      exp_wr = one << 7;
      beat(64'h55, one << 3, one << 7, 1'b0);
      total++;
      if (bus.batch_read_mask !== (one << 3) || bus.batch_write_mask !== exp_wr) begin
         bad++; $display("FAIL mask_first_beat: got rd=%h wr=%h want rd bit3 wr bit7",
                         bus.batch_read_mask, bus.batch_write_mask);
      end
      beat(64'h56, one << 200, '0, 1'b1);
      total++;
      if (bus.batch_read_mask !== exp_rd || bus.batch_write_mask !== exp_wr) begin
         bad++; $display("FAIL mask_union: got rd=%h wr=%h want rd bits3,200 wr bit7",
                         bus.batch_read_mask, bus.batch_write_mask);
      end
      drain(2);
      complete(0);
      complete(1);
      total += 2;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL mask_retire: got %b want 1", bus.batch_retired); end
      if (bus.batch_read_mask !== exp_rd || bus.batch_write_mask !== exp_wr) begin
         bad++; $display("FAIL mask_held_in_retire: got rd=%h wr=%h want rd bits3,200 wr bit7",
                         bus.batch_read_mask, bus.batch_write_mask);
      end
      tick();
      total += 3;
      if (bus.batch_read_mask !== '0 || bus.batch_write_mask !== '0) begin
         bad++; $display("FAIL mask_cleared: got rd=%h wr=%h want 0", bus.batch_read_mask, bus.batch_write_mask);
      end
      if (bus.batches_retired !== 32'd4) begin bad++; $display("FAIL mask_batches: got %0d want 4", bus.batches_retired); end
      if (bus.txns_dispatched !== 32'd17) begin bad++; $display("FAIL mask_txns: got %0d want 17", bus.txns_dispatched); end
   endtask

   task automatic test_illegal();
      // Out-of-range slot on a 3-transaction batch.
      do_reset();
      beat(64'hC0, '0, '0, 1'b0);
      beat(64'hC1, '0, '0, 1'b0);
      beat(64'hC2, '0, '0, 1'b1);
      drain(3);
      total++;
      if (bus.completion_error !== 1'b0) begin bad++; $display("FAIL ill_pre_error: got %b want 0", bus.completion_error); end
      complete(5);
      total++;
      if (bus.completion_error !== 1'b1) begin bad++; $display("FAIL ill_slot5: got %b want 1", bus.completion_error); end
      complete(0);
      complete(1);
      total += 2;
      if (bus.batch_retired !== 1'b0) begin bad++; $display("FAIL ill_slot5_early_retire: got 1 want 0"); end
      if (bus.completion_error !== 1'b1) begin bad++; $display("FAIL ill_sticky: got %b want 1", bus.completion_error); end
      complete(2);
      total++;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL ill_slot5_retire: got %b want 1", bus.batch_retired); end

      // Duplicate completion of slot 0.
      do_reset();
      total++;
      if (bus.completion_error !== 1'b0) begin bad++; $display("FAIL ill_reset_clears: got %b want 0", bus.completion_error); end
      beat(64'hC4, '0, '0, 1'b0);
      beat(64'hC5, '0, '0, 1'b0);
      beat(64'hC6, '0, '0, 1'b1);
      drain(3);
      complete(0);
      total++;
      if (bus.completion_error !== 1'b0) begin bad++; $display("FAIL ill_legal_first: got %b want 0", bus.completion_error); end
      complete(0);
      total++;
      if (bus.completion_error !== 1'b1) begin bad++; $display("FAIL ill_duplicate: got %b want 1", bus.completion_error); end
      complete(1);
      total++;
      if (bus.batch_retired !== 1'b0) begin bad++; $display("FAIL ill_dup_early_retire: got 1 want 0"); end
      complete(2);
      total++;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL ill_dup_retire: got %b want 1", bus.batch_retired); end

      // Completion while collecting.
      do_reset();
      complete(0);
      total += 2;
      if (bus.completion_error !== 1'b1) begin bad++; $display("FAIL ill_collect: got %b want 1", bus.completion_error); end
      if (bus.s_axis_tready !== 1'b1 || bus.d_valid !== 1'b0) begin
         bad++; $display("FAIL ill_collect_state: got tready=%b d_valid=%b want 1/0", bus.s_axis_tready, bus.d_valid);
      end
   endtask

   task automatic test_reset_mid_dispatch();
      logic [MD-1:0] one;
      one = MD'(1);
      do_reset();
      beat(64'hD0, one << 9, one << 11, 1'b0);
      beat(64'hD1, '0, '0, 1'b0);
      beat(64'hD2, '0, '0, 1'b1);
      drain(1);
      total++;
      if (bus.d_valid !== 1'b1 || bus.d_slot !== SW'(1)) begin
         bad++; $display("FAIL rst_pre: got v=%b slot=%0d want v=1 slot=1", bus.d_valid, bus.d_slot);
      end
      rst = 1'b1;
      #1;
      total += 4;
      if (bus.d_valid !== 1'b0 || bus.d_programID !== 64'd0 || bus.d_slot !== '0) begin
         bad++; $display("FAIL rst_async_dispatch: got v=%b id=%h slot=%0d want 0/0/0", bus.d_valid, bus.d_programID, bus.d_slot);
      end
      if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_async_tready: got %b want 1", bus.s_axis_tready); end
      if (bus.batch_read_mask !== '0 || bus.batch_write_mask !== '0) begin bad++; $display("FAIL rst_async_masks: got nonzero want 0"); end
      if (bus.txns_dispatched !== 32'd0) begin bad++; $display("FAIL rst_async_txns: got %0d want 0", bus.txns_dispatched); end
      tick();
      rst = 1'b0;
      tick();
      beat(64'hE0, '0, '0, 1'b1);
      total++;
      if (bus.d_valid !== 1'b1 || bus.d_programID !== 64'hE0 || bus.d_slot !== '0) begin
         bad++; $display("FAIL rst_new_batch: got v=%b id=%h slot=%0d want v=1 id=e0 slot=0", bus.d_valid, bus.d_programID, bus.d_slot);
      end
      drain(1);
      complete(0);
      total++;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL rst_new_retire: got %b want 1", bus.batch_retired); end
      tick();
      total++;
      if (bus.batches_retired !== 32'd1 || bus.txns_dispatched !== 32'd1) begin
         bad++; $display("FAIL rst_new_counters: got %0d/%0d want 1/1", bus.batches_retired, bus.txns_dispatched);
      end
   endtask

`ifdef BATCH_DISPATCHER_WATCHDOG_EN
   task automatic test_watchdog();
      do_reset();
      beat(64'hF0, '0, '0, 1'b0);
      beat(64'hF1, '0, '0, 1'b1);
      drain(2);
      complete(0);
      // Now one cycle after the last legal completion; retire lands 16 after.
      for (int c = 1; c < 15; c++) begin
         tick();
         total++;
         if (bus.batch_retired !== 1'b0 || bus.watchdog_timeout !== 1'b0) begin
            bad++; $display("FAIL wd_early_c%0d: got retired=%b timeout=%b want 0/0", c + 1, bus.batch_retired, bus.watchdog_timeout);
         end
      end
      tick();
      total += 2;
      if (bus.batch_retired !== 1'b1) begin bad++; $display("FAIL wd_retire: got %b want 1", bus.batch_retired); end
      if (bus.watchdog_timeout !== 1'b1) begin bad++; $display("FAIL wd_flag: got %b want 1", bus.watchdog_timeout); end
      tick();
      total += 2;
      if (bus.batches_retired !== 32'd1 || bus.s_axis_tready !== 1'b1) begin
         bad++; $display("FAIL wd_after: got batches=%0d tready=%b want 1/1", bus.batches_retired, bus.s_axis_tready);
      end
      if (bus.watchdog_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b want 1", bus.watchdog_timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_auto_close();
      test_batch_end();
      test_backpressure();
      test_masks();
      test_illegal();
      test_reset_mid_dispatch();
`ifdef BATCH_DISPATCHER_WATCHDOG_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
